// File: rtl/fifo_sync_ex.sv
// Parametrised synchronous FIFO: standard/FWFT read mode, level, almost-full/empty, flush.
// Optional sticky overflow/underflow ports when FIFO_ERR_FLAGS_EN is defined.
module fifo_sync_ex #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDR_WIDTH    = 4,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = (2 ** ADDR_WIDTH) - 2,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_ready,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  almost_full,
    output logic                  almost_empty
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   FULL_LVL = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AF_T     = (ADDR_WIDTH + 1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0]   AE_T     = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);
    localparam logic [ADDR_WIDTH:0]   LVL_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

    generate
        if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
            $error("fifo_sync_ex: AFULL_THRESH out of range 1..DEPTH");
        end
        if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
            $error("fifo_sync_ex: AEMPTY_THRESH out of range 0..DEPTH-1");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;

    // Handshake: a write transfers on a rising edge when wr_en & wr_ready, a read when
    // rd_en & rd_ready. A full FIFO still takes a write in the same cycle as an accepted
    // read (the freed slot is reused), and flush overrides both requests.
    assign wr_ready     = (level != FULL_LVL);
    assign rd_ready     = (level != '0);
    assign almost_full  = (level >= AF_T);
    assign almost_empty = (level <= AE_T);
    assign rd_acc       = rd_en & rd_ready & ~flush;
    assign wr_acc       = wr_en & (wr_ready | rd_acc) & ~flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
            case ({wr_acc, rd_acc})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= wr_data;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head entry is presented directly; zero while empty so reset shows 0.
            assign rd_data = rd_ready ? mem[rd_ptr] : '0;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] rd_data_q;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)        rd_data_q <= '0;
                else if (rd_acc) rd_data_q <= mem[rd_ptr];
            end
            assign rd_data = rd_data_q;
        end
    endgenerate

`ifdef FIFO_ERR_FLAGS_EN
    // Flags record refused requests only; a write paired with a read at full is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && !wr_acc) overflow  <= 1'b1;
            if (rd_en && !rd_ready) underflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_sync_ex.sv
// Directed bench for fifo_sync_ex: standard-read instance plus an FWFT instance.
// Error-flag checks are compiled in when FIFO_ERR_FLAGS_EN is defined.
module tb_fifo_sync_ex;

    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;

    logic          flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready, rd_ready, almost_full, almost_empty;
    logic [DW-1:0] rd_data;
    logic [AW:0]   level;

    logic          f_flush = 1'b0, f_wr_en = 1'b0, f_rd_en = 1'b0;
    logic [DW-1:0] f_wr_data = '0;
    logic          f_wr_ready, f_rd_ready, f_almost_full, f_almost_empty;
    logic [DW-1:0] f_rd_data;
    logic [AW:0]   f_level;

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow, underflow, f_overflow, f_underflow;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_v;

    fifo_sync_ex #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .wr_ready(wr_ready), .rd_en(rd_en), .rd_data(rd_data), .rd_ready(rd_ready),
        .level(level), .almost_full(almost_full), .almost_empty(almost_empty)
`ifdef FIFO_ERR_FLAGS_EN
        , .overflow(overflow), .underflow(underflow)
`endif
    );

    fifo_sync_ex #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .flush(f_flush), .wr_en(f_wr_en), .wr_data(f_wr_data),
        .wr_ready(f_wr_ready), .rd_en(f_rd_en), .rd_data(f_rd_data), .rd_ready(f_rd_ready),
        .level(f_level), .almost_full(f_almost_full), .almost_empty(f_almost_empty)
`ifdef FIFO_ERR_FLAGS_EN
        , .overflow(f_overflow), .underflow(f_underflow)
`endif
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // driver / check tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset values
        #2;
        check("rst_level", 32'(level), 0);
        check("rst_wr_ready", 32'(wr_ready), 1);
        check("rst_rd_ready", 32'(rd_ready), 0);
        check("rst_aempty", 32'(almost_empty), 1);
        check("rst_afull", 32'(almost_full), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        step();
        rst = 1'b1;
        step();

        // fill 0x0001..0x0010
        for (int i = 1; i <= 16; i++) begin
            wr_en = 1'b1; wr_data = DW'(i);
            step();
            exp_q.push_back(DW'(i));
            check("fill_level", 32'(level), 32'(i));
            check("fill_aempty", 32'(almost_empty), (i <= 1) ? 1 : 0);
            check("fill_afull", 32'(almost_full), (i >= 14) ? 1 : 0);
        end
        check("full_wr_ready", 32'(wr_ready), 0);
        wr_data = 16'hDEAD;
        step();
        wr_en = 1'b0;
        check("ovf_level", 32'(level), 16);
`ifdef FIFO_ERR_FLAGS_EN
        check("ovf_flag", 32'(overflow), 1);
`endif

        // drain, each value visible one cycle after rd_en edge
        for (int i = 1; i <= 16; i++) begin
            rd_en = 1'b1;
            step();
            exp_v = exp_q.pop_front();
            check("drain_data", 32'(rd_data), 32'(exp_v));
            check("drain_level", 32'(level), 32'(16 - i));
        end
        rd_en = 1'b0;
        check("empty_rd_ready", 32'(rd_ready), 0);
        check("empty_wr_ready", 32'(wr_ready), 1);

        // empty + simultaneous wr/rd: only the write lands
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 16'h7777;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        check("emptywr_level", 32'(level), 1);
        check("emptywr_data", 32'(rd_data), 32'h0010);
`ifdef FIFO_ERR_FLAGS_EN
        check("udf_flag", 32'(underflow), 1);
        check("ovf_sticky", 32'(overflow), 1);
`endif

        // bring level to 7, then flush with a write pending
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = DW'(16'h0100 + i);
            step();
        end
        check("pre_flush_level", 32'(level), 7);
        flush = 1'b1; wr_data = 16'hBEEF;
        step();
        flush = 1'b0; wr_en = 1'b0;
        check("flush_level", 32'(level), 0);
        check("flush_rd_ready", 32'(rd_ready), 0);
        check("flush_aempty", 32'(almost_empty), 1);
        check("flush_rd_data", 32'(rd_data), 32'h0010);
`ifdef FIFO_ERR_FLAGS_EN
        check("flush_ovf", 32'(overflow), 0);
        check("flush_udf", 32'(underflow), 0);
`endif
        step();
        check("flush_drop", 32'(level), 0);

        // full, then simultaneous wr+rd: wrap pointers 3x, then 0x5555
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = DW'(16'h2000 + i);
            exp_q.push_back(wr_data);
            step();
        end
        check("full2_level", 32'(level), 16);
        rd_en = 1'b1;
        for (int k = 0; k < 49; k++) begin
            wr_data = (k == 48) ? 16'h5555 : DW'(16'h3000 + k);
            exp_q.push_back(wr_data);
            step();
            exp_v = exp_q.pop_front();
            check("wrap_data", 32'(rd_data), 32'(exp_v));
            check("wrap_level", 32'(level), 16);
        end
        wr_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            exp_v = exp_q.pop_front();
            check("wrap_drain", 32'(rd_data), 32'(exp_v));
        end
        rd_en = 1'b0;
        check("last_is_5555", 32'(rd_data), 32'h5555);
        check("wrap_empty", 32'(level), 0);

        // asynchronous reset mid-stream at level 5
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = DW'(16'h4000 + i);
            step();
        end
        check("pre_rst_level", 32'(level), 5);
        #2 rst = 1'b0;
        #1;
        check("arst_level", 32'(level), 0);
        check("arst_rd_data", 32'(rd_data), 0);
        check("arst_rd_ready", 32'(rd_ready), 0);
        check("arst_wr_ready", 32'(wr_ready), 1);
        check("arst_aempty", 32'(almost_empty), 1);
        step();
        check("arst_hold", 32'(level), 0);
        wr_en = 1'b0;
        rst = 1'b1;
        step();

        // FWFT instance
        check("fwft_empty", 32'(f_rd_ready), 0);
        f_wr_en = 1'b1; f_wr_data = 16'hABCD;
        step();
        f_wr_en = 1'b0;
        check("fwft_rd_ready", 32'(f_rd_ready), 1);
        check("fwft_data", 32'(f_rd_data), 32'hABCD);
        check("fwft_level", 32'(f_level), 1);
        f_rd_en = 1'b1;
        step();
        f_rd_en = 1'b0;
        check("fwft_pop_ready", 32'(f_rd_ready), 0);
        check("fwft_pop_level", 32'(f_level), 0);
        f_wr_en = 1'b1; f_wr_data = 16'h1111;
        step();
        f_wr_data = 16'h2222;
        step();
        f_wr_en = 1'b0;
        check("fwft_head1", 32'(f_rd_data), 32'h1111);
        f_rd_en = 1'b1;
        step();
        check("fwft_head2", 32'(f_rd_data), 32'h2222);
        check("fwft_head2_rdy", 32'(f_rd_ready), 1);
        step();
        f_rd_en = 1'b0;
        check("fwft_drained", 32'(f_rd_ready), 0);

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
